// File: rtl/ifft64_out_packer.sv
// ----------------------------------------------------------------------------
// ifft64_out_packer
//
// Output-side frame packer for the 64-point radix-2 IFFT. It collects the
// core's serial result stream (two complex samples per beat, BEATS beats per
// frame) into four BEATS*DW-bit words. The packing matches the core's input
// bank. Two banks are used, so one frame can drain while the next one fills.
// A frame that starts while the target bank is still full is dropped as a
// whole, and the sticky overflow flag is set.
//
// Ports:
//   clk          rising-edge clock
//   arstn        asynchronous active-low reset
//   in_valid     beat qualifier (core start_check)
//   in0_re/im,
//   in1_re/im    per-beat samples, DW bits each
//   frame_valid  bank at rd_ptr holds a complete frame
//   frame_ready  downstream accepts the presented frame
//   frame0_re/im,
//   frame1_re/im packed frame words, BEATS*DW bits each
//   frame_idx    sequence number of the presented frame
//   overflow     sticky drop indicator, cleared only by reset
// ----------------------------------------------------------------------------
module ifft64_out_packer #(
    parameter int BEATS = 32,
    parameter int DW    = 16,
    parameter int IDXW  = 10
) (
    input  logic                  clk,
    input  logic                  arstn,
    input  logic                  in_valid,
    input  logic [DW-1:0]         in0_re,
    input  logic [DW-1:0]         in0_im,
    input  logic [DW-1:0]         in1_re,
    input  logic [DW-1:0]         in1_im,
    output logic                  frame_valid,
    input  logic                  frame_ready,
    output logic [BEATS*DW-1:0]   frame0_re,
    output logic [BEATS*DW-1:0]   frame0_im,
    output logic [BEATS*DW-1:0]   frame1_re,
    output logic [BEATS*DW-1:0]   frame1_im,
    output logic [IDXW-1:0]       frame_idx,
    output logic                  overflow
);

    localparam int FW = BEATS * DW;
    localparam int BW = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

    // Bank storage, indexed by wr_ptr / rd_ptr.
    logic [FW-1:0]   b0_re [2];
    logic [FW-1:0]   b0_im [2];
    logic [FW-1:0]   b1_re [2];
    logic [FW-1:0]   b1_im [2];
    logic [IDXW-1:0] idx   [2];
    logic [1:0]      full;

    logic            wr_ptr;
    logic            rd_ptr;
    logic [BW-1:0]   beat;
    logic [IDXW-1:0] seq;
    logic            drop;

    logic            first_beat;
    logic            drop_now;
    logic            pop;

    // NOTE: every signal assigned in always_comb gets a default at the top so
    // no path can leave it unassigned and infer a latch.
    always_comb begin
        first_beat = 1'b0;
        drop_now   = drop;
        pop        = 1'b0;
        first_beat = in_valid && (beat == '0);
        // The drop decision is made on beat 0 and then latched, so a bank
        // that frees up mid-frame does not rescue the frame.
        if (first_beat) begin
            drop_now = full[wr_ptr];
        end
        pop = full[rd_ptr] && frame_ready;
    end

    // NOTE: all state here uses non-blocking assignments, so every read in
    // this block sees the pre-edge value regardless of statement order.
    // NOTE: the bank registers are reset too, because the frame words must
    // read as zero straight out of reset, not just the control bits.
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            for (int b = 0; b < 2; b++) begin
                b0_re[b] <= '0;
                b0_im[b] <= '0;
                b1_re[b] <= '0;
                b1_im[b] <= '0;
                idx[b]   <= '0;
            end
            full     <= '0;
            wr_ptr   <= 1'b0;
            rd_ptr   <= 1'b0;
            beat     <= '0;
            seq      <= '0;
            drop     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            // A pop frees bank[rd_ptr]. A completing frame can only target the
            // other bank, because it was accepted while its own bank was
            // empty. Both updates can therefore happen on the same edge.
            if (pop) begin
                full[rd_ptr] <= 1'b0;
                rd_ptr       <= ~rd_ptr;
            end

            if (in_valid) begin
                beat <= (beat == LAST_BEAT) ? '0 : beat + 1'b1;

                if (first_beat) begin
                    drop <= drop_now;
                    if (drop_now) begin
                        overflow <= 1'b1;
                    end
                end

                if (!drop_now) begin
                    b0_re[wr_ptr][DW*beat +: DW] <= in0_re;
                    b0_im[wr_ptr][DW*beat +: DW] <= in0_im;
                    b1_re[wr_ptr][DW*beat +: DW] <= in1_re;
                    b1_im[wr_ptr][DW*beat +: DW] <= in1_im;
                end

                // Dropped frames still consume a sequence number.
                if (beat == LAST_BEAT) begin
                    seq <= seq + 1'b1;
                    if (!drop_now) begin
                        full[wr_ptr] <= 1'b1;
                        idx[wr_ptr]  <= seq;
                        wr_ptr       <= ~wr_ptr;
                    end
                end
            end
        end
    end

    assign frame_valid = full[rd_ptr];
    assign frame0_re   = b0_re[rd_ptr];
    assign frame0_im   = b0_im[rd_ptr];
    assign frame1_re   = b1_re[rd_ptr];
    assign frame1_im   = b1_im[rd_ptr];
    assign frame_idx   = idx[rd_ptr];

endmodule

// File: doc/ifft64_out_packer.md
# ifft64_out_packer

Output-side frame packer for the 64-point radix-2 IFFT. It consumes the core's serial result stream: two complex 16-bit samples per cycle, qualified by `start_check`, 32 beats per frame. It reassembles each frame into four 512-bit words, in the same packing the core's input bank uses, and presents them downstream with a valid/ready handshake. The block is double-buffered, so one frame can drain while the next fills. Frames that arrive with no free buffer are dropped and flagged.

## Interface
Parameters:
- `BEATS`, 32: beats per frame; must be a power of two.
- `DW`, 16: sample width in bits.
- `IDXW`, 10: frame index width; matches `bank_addr`.

Ports:
- `clk`  in  1  single clock, rising-edge.
- `arstn`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  beat qualifier; driven by the core's `start_check`.
- `in0_re`, `in0_im`, `in1_re`, `in1_im`  in  DW each  per-beat output samples from the core.
- `frame_valid`  out  1  a complete frame is presented.
- `frame_ready`  in  1  downstream accepts the presented frame.
- `frame0_re`, `frame0_im`, `frame1_re`, `frame1_im`  out  BEATS*DW each  packed frame.
- `frame_idx`  out  IDXW  sequence number of the presented frame; dropped frames also consume a number.
- `overflow`  out  1  sticky; set when any frame is dropped; cleared only by reset.

## Operation
- Storage: two banks, A and B. Each bank holds four BEATS*DW registers plus a `full` bit and an IDXW index.
- Pointers and counters:
  - `wr_ptr` and `rd_ptr` are 1-bit.
  - `beat` is a log2(BEATS) counter.
  - `seq` is an IDXW counter.
- Packing: a beat `k` with `in_valid` writes `in0_re` into bits [DW*k+DW-1 : DW*k] of `frame0_re`. `in0_im`, `in1_re` and `in1_im` go to the same slice of their own words.
- `beat` advances on every valid beat and wraps 31->0. Dropped frames advance it too, so frame alignment is always kept.
- Frame start (`in_valid` and `beat`==0):
  - If bank[`wr_ptr`].full==0, the frame is accepted: `drop`=0.
  - Otherwise `drop`=1 for the whole frame and `overflow` is set.
  - `drop` is latched for all 32 beats. A bank freed mid-frame does not rescue the frame.
- Accepted frame: all 32 beats are written to bank[`wr_ptr`]. On the beat-31 edge, the block sets bank.full=1, sets bank.idx=`seq` and toggles `wr_ptr`.
- Dropped frame: no bank is written, and `wr_ptr` is unchanged.
- `seq` increments on every beat-31 edge, whether the frame was accepted or dropped, and wraps modulo 2^IDXW.
- Read side:
  - `frame_valid` = bank[`rd_ptr`].full.
  - The `frame*` words and `frame_idx` are driven from bank[`rd_ptr`].
  - When `frame_valid` and `frame_ready` are both high at a rising edge, the bank's full bit is cleared and `rd_ptr` toggles.
- Simultaneous pop of one bank and completion of the other in the same cycle: both take effect.
- Frame outputs are held stable while `frame_valid`=1 and `frame_ready`=0.
- `in_valid` gaps mid-frame: the frame simply stalls. There is no timeout.

## Timing
- Reset values (asynchronous): every bank register 0, full bits 0, `wr_ptr`=`rd_ptr`=0, `beat`=0, `seq`=0, `drop`=0, `overflow`=0. Therefore `frame_valid`=0, all frame words 0, `frame_idx`=0.
- Reset asserted mid-frame discards all partial and full frames. The first valid beat after release is beat 0.
- Latency: the edge that captures beat 31 makes `frame_valid`=1 in the following cycle, with no extra pipeline stage.
- Throughput:
  - With `frame_ready` held high, the bank is popped on the first edge after it becomes valid.
  - Continuous 32-beat frames are therefore never dropped.
  - Up to two frames can be buffered while `frame_ready`=0.
- `overflow` rises on the beat-0 edge of the first dropped frame.

## Test plan
- **Single frame:** after reset, drive 32 valid beats with `in0_re`=k, `in0_im`=0x100+k, `in1_re`=0x200+k, `in1_im`=0x300+k, `frame_ready`=1.
  - Required: `frame_valid` pulses exactly one cycle, starting the cycle after beat 31.
  - `frame0_re`[16k+15:16k]=k for all k (likewise for the other three words); `frame_idx`=0.
- **Continuous stream:** 1000 back-to-back frames with `frame_ready`=1.
  - Required: 1000 `frame_valid` pulses, `frame_idx` 0..999 in order, `overflow` stays 0.
- **Backpressure:** `frame_ready`=0 for 3 consecutive frames, then 1.
  - Required: frames 0 and 1 are delivered in order, with `frame_idx` 0 and 1.
  - Frame 2 is dropped and `overflow`=1 from its beat-0 edge.
  - The next accepted frame carries `frame_idx`=3.
- **Gapped input:** `in_valid` toggles 1,0,1,0 within a frame.
  - Required: packed data is identical to the gap-free case; `frame_valid` appears one cycle after the 32nd valid beat.
- **Simultaneous events:** hold `frame_ready`=0 until the second frame's beat 31, then assert it on that same edge.
  - Required: bank A pops and bank B fills on that edge, `frame_valid` stays 1 into the next cycle, and `frame_idx` goes 0 -> 1.
- **Reset mid-frame:** assert `arstn`=0 after beat 12.
  - Required: all outputs go to 0 immediately.
  - After release, a fresh 32-beat frame is delivered with `frame_idx`=0 and `overflow`=0.
